// File: rtl/if_fetch_unit.sv
// IF-stage PC generator and fetch sequencer.
// Runs the ROM req/ack handshake and fills the IF/ID register.
module if_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  rom_req,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ack,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] pending_addr;
    logic [ADDR_WIDTH-1:0] flush_tgt;
    logic                  pending_br;
    logic [DATA_WIDTH-1:0] hold_inst;

    logic                  br_taken;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] next_pc;

    // A branch only counts when ID really holds an instruction and advances.
    assign br_taken = branch_flag & ~stall & inst_valid;
    assign pc_inc   = fetch_pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
    // Redirect from ID first, then a redirect parked while the slot was late.
    assign next_pc  = br_taken   ? branch_addr  :
                      pending_br ? pending_addr : pc_inc;
    assign rom_addr = fetch_pc;

    // Fetch FSM, fetch PC, branch bookkeeping and the IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            rom_req      <= 1'b0;
            pc           <= '0;
            inst         <= '0;
            inst_valid   <= 1'b0;
            pending_br   <= 1'b0;
            pending_addr <= '0;
            hold_inst    <= '0;
            flush_tgt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state   <= S_REQ;
                    rom_req <= 1'b1;
                end
                S_REQ: begin
                    if (flush) begin
                        inst_valid <= 1'b0;
                        pending_br <= 1'b0;
                        if (rom_ack) begin
                            fetch_pc <= flush_pc;
                        end else begin
                            flush_tgt <= flush_pc;
                            state     <= S_DRAIN;
                        end
                    end else if (rom_ack && !stall) begin
                        pc         <= fetch_pc;
                        inst       <= rom_rdata;
                        inst_valid <= 1'b1;
                        fetch_pc   <= next_pc;
                        pending_br <= 1'b0;
                    end else if (rom_ack) begin
                        // ID is stalled: park the word, stop requesting.
                        hold_inst <= rom_rdata;
                        state     <= S_HOLD;
                        rom_req   <= 1'b0;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        if (br_taken) begin
                            pending_br   <= 1'b1;
                            pending_addr <= branch_addr;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        inst_valid <= 1'b0;
                        pending_br <= 1'b0;
                        fetch_pc   <= flush_pc;
                        state      <= S_REQ;
                        rom_req    <= 1'b1;
                    end else if (!stall) begin
                        pc         <= fetch_pc;
                        inst       <= hold_inst;
                        inst_valid <= 1'b1;
                        fetch_pc   <= next_pc;
                        pending_br <= 1'b0;
                        state      <= S_REQ;
                        rom_req    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Old request stays on the bus until answered; data dropped.
                    inst_valid <= 1'b0;
                    pending_br <= 1'b0;
                    if (flush) begin
                        flush_tgt <= flush_pc;
                    end
                    if (rom_ack) begin
                        fetch_pc <= flush ? flush_pc : flush_tgt;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rom_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
